// File: rtl/muldiv_unit.sv
// muldiv_unit
//   Iterative RV32M multiply/divide execute unit. One operation is taken per
//   start pulse while idle. Multiplies use a radix-2 shift-add loop and
//   divides use a restoring-division loop. Each loop runs for 32 iterations.
//   The RISC-V-defined result is returned with a one-cycle done pulse.
//
//   Optional build macro: MULDIV_FAST_MUL_EN
//     When defined, all multiply ops finish through a single-cycle
//     combinational 64-bit product. Division is not affected.
//
//   Ports
//     clk    : rising-edge clock
//     rst    : asynchronous active-high reset
//     start  : launch request, sampled only while busy = 0
//     op     : funct3 (000 MUL, 001 MULH, 010 MULHSU, 011 MULHU,
//                      100 DIV, 101 DIVU, 110 REM,    111 REMU)
//     rs1    : dividend / multiplicand
//     rs2    : divisor / multiplier
//     busy   : high whenever the unit is not idle
//     done   : single-cycle completion pulse
//     result : registered result, held until the next completion
module muldiv_unit #(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] rs2,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam int unsigned CW = $clog2(XLEN);

  localparam logic [2:0] OP_MUL    = 3'b000;
  localparam logic [2:0] OP_MULH   = 3'b001;
  localparam logic [2:0] OP_MULHSU = 3'b010;
  localparam logic [2:0] OP_MULHU  = 3'b011;
  localparam logic [2:0] OP_DIV    = 3'b100;
  localparam logic [2:0] OP_DIVU   = 3'b101;
  localparam logic [2:0] OP_REM    = 3'b110;

  typedef enum logic [1:0] {
    S_IDLE,
    S_CALC,
    S_FIX,
    S_DONE
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [2:0]      op_q, op_d;
  logic [XLEN-1:0] mag_q, mag_d;     // multiplicand or divisor magnitude
  logic [XLEN-1:0] hi_q, hi_d;       // product high half / partial remainder
  logic [XLEN-1:0] lo_q, lo_d;       // multiplier+product low / dividend+quotient
  logic            neg1_q, neg1_d;   // rs1 was negative and signed
  logic            neg2_q, neg2_d;   // rs2 was negative and signed
  logic [XLEN-1:0] result_q, result_d;

  // Operand decode for the launch cycle
  logic            in_s1, in_s2, in_neg1, in_neg2;
  logic [XLEN-1:0] in_mag1, in_mag2;
  logic            div_by_zero, div_ovf;

  // Iteration datapaths
  logic [XLEN:0]   mul_sum;
  logic [XLEN:0]   div_shift;
  logic [XLEN:0]   div_diff;

  // Final sign correction
  logic [2*XLEN-1:0] prod_fix;
  logic [XLEN-1:0]   quo_fix, rem_fix;

`ifdef MULDIV_FAST_MUL_EN
  logic [2*XLEN-1:0] fast_a, fast_b, fast_prod;
`endif

  always_comb begin
    in_s1   = (op == OP_MULH) || (op == OP_MULHSU) || (op == OP_DIV) || (op == OP_REM);
    in_s2   = (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
    in_neg1 = in_s1 && rs1[XLEN-1];
    in_neg2 = in_s2 && rs2[XLEN-1];
    in_mag1 = in_neg1 ? -rs1 : rs1;
    in_mag2 = in_neg2 ? -rs2 : rs2;
    div_by_zero = op[2] && (rs2 == '0);
    div_ovf     = op[2] && !op[0] && (rs1 == {1'b1, {(XLEN-1){1'b0}}}) && (rs2 == '1);

    // Shift-add: add the multiplicand into the high half when the current
    // multiplier bit is set, then shift the whole 64-bit pair right by one.
    mul_sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, mag_q} : '0);

    // Restoring divide: shift the next dividend bit into the remainder. The
    // borrow bit of the trial subtraction decides whether the result is kept.
    div_shift = {hi_q, lo_q[XLEN-1]};
    div_diff  = div_shift - {1'b0, mag_q};

    prod_fix = (neg1_q ^ neg2_q) ? -{hi_q, lo_q} : {hi_q, lo_q};
    quo_fix  = (neg1_q ^ neg2_q) ? -lo_q : lo_q;
    rem_fix  = neg1_q ? -hi_q : hi_q;

`ifdef MULDIV_FAST_MUL_EN
    fast_a    = in_s1 ? {{XLEN{rs1[XLEN-1]}}, rs1} : {{XLEN{1'b0}}, rs1};
    fast_b    = in_s2 ? {{XLEN{rs2[XLEN-1]}}, rs2} : {{XLEN{1'b0}}, rs2};
    fast_prod = fast_a * fast_b;
`endif
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    op_d     = op_q;
    mag_d    = mag_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    neg1_d   = neg1_q;
    neg2_d   = neg2_q;
    result_d = result_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          op_d   = op;
          neg1_d = in_neg1;
          neg2_d = in_neg2;
          cnt_d  = '0;
          hi_d   = '0;
          if (op[2]) begin
            mag_d = in_mag2;
            lo_d  = in_mag1;
          end else begin
            mag_d = in_mag1;
            lo_d  = in_mag2;
          end

          if (div_by_zero) begin
            result_d = op[1] ? rs1 : '1;
            state_d  = S_DONE;
          end else if (div_ovf) begin
            result_d = op[1] ? '0 : {1'b1, {(XLEN-1){1'b0}}};
            state_d  = S_DONE;
          end
`ifdef MULDIV_FAST_MUL_EN
          else if (!op[2]) begin
            result_d = (op == OP_MUL) ? fast_prod[XLEN-1:0] : fast_prod[2*XLEN-1:XLEN];
            state_d  = S_DONE;
          end
`endif
          else begin
            state_d = S_CALC;
          end
        end
      end

      S_CALC: begin
        if (op_q[2]) begin
          if (!div_diff[XLEN]) begin
            hi_d = div_diff[XLEN-1:0];
            lo_d = {lo_q[XLEN-2:0], 1'b1};
          end else begin
            hi_d = div_shift[XLEN-1:0];
            lo_d = {lo_q[XLEN-2:0], 1'b0};
          end
        end else begin
          hi_d = mul_sum[XLEN:1];
          lo_d = {mul_sum[0], lo_q[XLEN-1:1]};
        end
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(XLEN-1)) begin
          state_d = S_FIX;
        end
      end

      S_FIX: begin
        case (op_q)
          OP_MUL:                       result_d = prod_fix[XLEN-1:0];
          OP_MULH, OP_MULHSU, OP_MULHU: result_d = prod_fix[2*XLEN-1:XLEN];
          OP_DIV, OP_DIVU:              result_d = quo_fix;
          default:                      result_d = rem_fix;
        endcase
        state_d = S_DONE;
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      op_q     <= '0;
      mag_q    <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      neg1_q   <= 1'b0;
      neg2_q   <= 1'b0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      op_q     <= op_d;
      mag_q    <= mag_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      neg1_q   <= neg1_d;
      neg2_q   <= neg2_d;
      result_q <= result_d;
    end
  end

  assign busy   = (state_q != S_IDLE);
  assign done   = (state_q == S_DONE);
  assign result = result_q;

endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Iterative RV32M multiply/divide execute unit. It sits directly downstream of the instruction decoder and takes every R-type instruction that the decoder flags as an M-extension op: opcode 0110011, funct7 0000001, `enable` = 0. The unit accepts one operation per start pulse and runs a radix-2 shift-add or restoring-division loop. It returns the 32-bit RISC-V-defined result with a one-cycle `done` pulse, and the pipeline stalls on `busy`.

## Interface
- `XLEN`, 32: operand/result width; only 32 is supported.
- `clk` input 1: rising-edge clock.
- `rst` input 1: asynchronous, active-high reset.
- `start` input 1: launch request; sampled only when `busy` = 0.
- `op` input 3: funct3 code, equal to the decoder's alu_control[2:0] when enable = 0.
  - 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU
  - 100 DIV, 101 DIVU, 110 REM, 111 REMU
- `rs1` input 32: dividend / multiplicand.
- `rs2` input 32: divisor / multiplier.
- `busy` output 1: high whenever state ≠ IDLE.
- `done` output 1: single-cycle completion pulse.
- `result` output 32: registered result.

## Operation
- **States**
  - IDLE: `start` = 1 captures `op`, `rs1`, `rs2`, operand signs and magnitudes.
    - Special cases go to DONE.
    - Fast multiply (see Configuration) goes to DONE.
    - Everything else goes to CALC with counter = 0.
  - CALC: one iteration per clock, counter 0..31. At counter = 31 go to FIX.
  - FIX: sign correction and result select. Go to DONE.
  - DONE: `done` = 1, `result` valid. Go to IDLE.
- **Signedness**
  - Signed operand: MULH/DIV/REM treat both operands as signed; MULHSU treats `rs1` only.
  - Signed operands are converted to magnitudes in IDLE.
  - Multiply: 64-bit unsigned product of the magnitudes; FIX negates it (two's complement, 64-bit) when the operand signs differ.
  - Divide: 32-bit restoring division on magnitudes.
    - Quotient is negated when the signs differ (DIV only).
    - Remainder takes the dividend's sign (REM only).
- **Result select**
  - MUL: product[31:0].
  - MULH/MULHSU/MULHU: product[63:32].
  - DIV/DIVU: quotient.
  - REM/REMU: remainder.
- **Special cases** (resolved in IDLE, no CALC)
  - `rs2` = 0, any divide op: DIV/DIVU give 0xFFFFFFFF; REM/REMU give `rs1`.
  - DIV/REM with `rs1` = 0x80000000 and `rs2` = 0xFFFFFFFF: DIV gives 0x80000000, REM gives 0.
- **Start handling**
  - `start` while `busy` = 1 (CALC, FIX or DONE) is ignored; no queueing.
  - Captured operands are unaffected by input changes after acceptance.
- **Hold and reset**
  - `result` holds its last value until the next DONE.
  - `rst` at any time, including mid-CALC: state = IDLE, counter = 0, `busy` = 0, `done` = 0, `result` = 0, internal accumulators = 0. The aborted operation is discarded with no `done`.

## Timing
- Reset values: `busy` = 0, `done` = 0, `result` = 0x00000000.
- Edge numbering: the edge that samples `start` is edge 0.
- Iterative path: CALC spans edges 1..32, FIX edge 33, DONE edge 34.
  - `done` is high for the one cycle following edge 33.
  - Latency start→done = 33 clocks.
- Special-case and fast-multiply path: `done` is high for the cycle following edge 0 (latency 1).
- `busy` rises in the cycle after edge 0 and falls the cycle after `done`.
- Back-to-back issue: a new `start` is accepted at the edge ending the DONE cycle's successor, i.e. the first cycle with `busy` = 0.
- `done` and `busy` are both high during DONE.

## Configuration
- Macro: `MULDIV_FAST_MUL_EN`.
- Defined:
  - All four multiply ops use a single-cycle combinational 64-bit signed/unsigned multiply, registered at edge 0. Latency is 1 clock.
  - Division is unchanged.
- Undefined:
  - Multiply ops take the 32-iteration shift-add path with 33-clock latency.
  - No hardware multiplier is inferred.
- Both builds produce identical `result` values for all inputs.

## Test plan
- MUL `rs1` = 7, `rs2` = −3 (0xFFFFFFFD) → `result` 0xFFFFFFEB.
  - `done` after 33 clocks without the macro, 1 clock with it.
- MULH 0x80000000 × 0x80000000 → 0x40000000; MULHU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFE; MULHSU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFF.
- DIV −7 / 2 → 0xFFFFFFFD, REM −7 % 2 → 0xFFFFFFFF, DIVU 100 / 7 → 14, REMU 100 % 7 → 2. Each `done` exactly 33 clocks after start.
- DIVU 5 / 0 → 0xFFFFFFFF and REM 5 % 0 → 5; DIV 0x80000000 / −1 → 0x80000000. Each `done` 1 clock after start.
- Issue DIV, pulse `start` with a MUL at clocks 5 and 33 → ignored.
  - Exactly one `done`, carrying the DIV result.
  - A MUL started on the first `busy` = 0 cycle is accepted.
- Assert `rst` for 1 cycle at clock 10 of a DIV.
  - `busy`/`done`/`result` immediately go to 0, and no `done` appears.
  - A following DIVU 9 / 3 returns 3.
